mem_access_stage: RTL and testbench

Consumer side of the EX/MEM pipeline register in the 8-bit core.
- Takes the registered EX/MEM fields and performs the load/store on the data-memory bus using a req/ack handshake with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the results into the MEM/WB-side outputs consumed by write-back.

---
 rtl/mem_access_stage_if.sv | 13 +
 rtl/mem_access_stage.sv | 119 +++++++++++
 tb/tb_mem_access_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/acknowledge bus between the MEM stage and data memory
// master (stage): drives dm_req, dm_we, dm_addr, dm_wdata; samples dm_ack, dm_rdata
// slave (memory): the reverse
interface mem_access_stage_if #(parameter int DATA_W = 8);
  logic              dm_req;
  logic              dm_we;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM consumer doing loads/stores over a req/ack bus, stalling upstream, feeding MEM/WB
// clk, rst (async, active-low); EX/MEM fields in; dm bus via mem_access_stage_if.master;
// mem_stall/mem_err status out; wb_* MEM/WB fields out.
// Define MEM_TIMEOUT_EN to abort an access after MAX_WAIT unacknowledged cycles (mem_err pulse).
module mem_access_stage #(
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] Rd2,
  input  logic [1:0]        RegDistidx,
  input  logic [DATA_W-1:0] ALU_res,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemToReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] IP,
  mem_access_stage_if.master dm,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [DATA_W-1:0] wb_pc_plus1,
  output logic [DATA_W-1:0] wb_alu_res,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_ip,
  output logic [1:0]        wb_RegDistidx,
  output logic [1:0]        wb_MemToReg,
  output logic              wb_RegWrite
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t            state, state_n;
  logic              memop, timeout;
  logic [DATA_W-1:0] l_pc, l_ip;
  logic [1:0]        l_idx, l_mtr;
  logic              l_rw;
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end
  assign memop = MemRead | MemWrite;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  // cnt holds the number of ACCESS cycles already spent, so cnt==MAX_WAIT-1 marks the last allowed one
  assign timeout = (state == ACCESS) && !dm.dm_ack && (cnt == CW'(MAX_WAIT - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt     <= (state == ACCESS) ? cnt + CW'(1) : '0;
      mem_err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end
  // stall is gated by rst so an asserted reset releases the pipeline immediately
  always_comb begin
    state_n   = (state == IDLE) ? (memop ? ACCESS : IDLE) : ((dm.dm_ack | timeout) ? IDLE : ACCESS);
    mem_stall = rst & ((state == IDLE) ? memop : (~dm.dm_ack & ~timeout));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm.dm_req     <= 1'b0;
      dm.dm_we      <= 1'b0;
      dm.dm_addr    <= '0;
      dm.dm_wdata   <= '0;
      l_pc          <= '0;
      l_ip          <= '0;
      l_idx         <= '0;
      l_mtr         <= '0;
      l_rw          <= 1'b0;
      wb_pc_plus1   <= '0;
      wb_alu_res    <= '0;
      wb_mem_data   <= '0;
      wb_ip         <= '0;
      wb_RegDistidx <= '0;
      wb_MemToReg   <= '0;
      wb_RegWrite   <= 1'b0;
    end else if (state == IDLE && memop) begin
      dm.dm_req   <= 1'b1;
      dm.dm_we    <= MemWrite;
      dm.dm_addr  <= ALU_res;
      dm.dm_wdata <= Rd2;
      l_pc        <= pc_plus1;
      l_ip        <= IP;
      l_idx       <= RegDistidx;
      l_mtr       <= MemToReg;
      l_rw        <= RegWrite;
      wb_RegWrite <= 1'b0;
    end else if (state == IDLE) begin
      wb_pc_plus1   <= pc_plus1;
      wb_alu_res    <= ALU_res;
      wb_mem_data   <= '0;
      wb_ip         <= IP;
      wb_RegDistidx <= RegDistidx;
      wb_MemToReg   <= MemToReg;
      wb_RegWrite   <= RegWrite;
    end else if (dm.dm_ack | timeout) begin
      // dm_addr still holds the latched ALU result, so it doubles as the wb_alu_res source
      dm.dm_req     <= 1'b0;
      wb_pc_plus1   <= l_pc;
      wb_alu_res    <= dm.dm_addr;
      wb_mem_data   <= dm.dm_ack ? (dm.dm_we ? '0 : dm.dm_rdata) : '1;
      wb_ip         <= l_ip;
      wb_RegDistidx <= l_idx;
      wb_MemToReg   <= l_mtr;
      wb_RegWrite   <= dm.dm_ack & l_rw;
    end else begin
      wb_RegWrite <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of pass-through, load, store, back-to-back, reset and timeout
module tb_mem_access_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_plus1, Rd2, ALU_res, IP;
  logic [1:0] RegDistidx, MemToReg;
  logic       MemRead, MemWrite, RegWrite;
  logic       mem_stall, mem_err;
  logic [7:0] wb_pc_plus1, wb_alu_res, wb_mem_data, wb_ip;
  logic [1:0] wb_RegDistidx, wb_MemToReg;
  logic       wb_RegWrite;
  int         n_cmp = 0;
  int         n_bad = 0;
  mem_access_stage_if #(.DATA_W(8)) dm();
  mem_access_stage #(.DATA_W(8), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .pc_plus1(pc_plus1), .Rd2(Rd2), .RegDistidx(RegDistidx),
    .ALU_res(ALU_res), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .IP(IP), .dm(dm.master), .mem_stall(mem_stall), .mem_err(mem_err),
    .wb_pc_plus1(wb_pc_plus1), .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data), .wb_ip(wb_ip),
    .wb_RegDistidx(wb_RegDistidx), .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite)
  );
  always #5 clk = ~clk;

  task automatic set_nop();
    pc_plus1 = 8'h00; Rd2 = 8'h00; ALU_res = 8'h00; IP = 8'h00;
    RegDistidx = 2'd0; MemToReg = 2'd0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    dm.dm_ack = 1'b0; dm.dm_rdata = 8'h00;
  endtask

  task automatic test_reset();
    set_nop();
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (dm.dm_req !== 1'b0) begin n_bad++; $display("FAIL reset dm_req got %b exp 0", dm.dm_req); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset mem_stall got %b exp 0", mem_stall); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset mem_err got %b exp 0", mem_err); end
    n_cmp++; if ({wb_pc_plus1, wb_alu_res, wb_mem_data, wb_ip, wb_RegDistidx, wb_MemToReg, wb_RegWrite} !== 37'd0)
      begin n_bad++; $display("FAIL reset wb_fields got %h/%h/%h/%h exp 0", wb_pc_plus1, wb_alu_res, wb_mem_data, wb_ip); end
    rst = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    ALU_res = 8'h3C; RegWrite = 1'b1; RegDistidx = 2'd2; MemToReg = 2'd0; pc_plus1 = 8'h05; IP = 8'h77;
    #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL alu mem_stall got %b exp 0", mem_stall); end
    @(negedge clk);
    set_nop();
    n_cmp++; if (wb_alu_res !== 8'h3C) begin n_bad++; $display("FAIL alu wb_alu_res got %h exp 3c", wb_alu_res); end
    n_cmp++; if (wb_RegWrite !== 1'b1) begin n_bad++; $display("FAIL alu wb_RegWrite got %b exp 1", wb_RegWrite); end
    n_cmp++; if (wb_RegDistidx !== 2'd2) begin n_bad++; $display("FAIL alu wb_RegDistidx got %0d exp 2", wb_RegDistidx); end
    n_cmp++; if (wb_pc_plus1 !== 8'h05 || wb_ip !== 8'h77) begin n_bad++; $display("FAIL alu pc/ip got %h/%h exp 05/77", wb_pc_plus1, wb_ip); end
    n_cmp++; if (dm.dm_req !== 1'b0) begin n_bad++; $display("FAIL alu dm_req got %b exp 0", dm.dm_req); end
    @(negedge clk);
    n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL alu wb_RegWrite_once got %b exp 0", wb_RegWrite); end
  endtask

  task automatic test_load();
    MemRead = 1'b1; ALU_res = 8'h10; RegWrite = 1'b1; RegDistidx = 2'd1; MemToReg = 2'd1; pc_plus1 = 8'h11;
    for (int k = 0; k < 4; k++) begin
      dm.dm_ack = (k == 3); dm.dm_rdata = (k == 3) ? 8'hA5 : 8'h00;
      if (k == 1) ALU_res = 8'hEE;
      #1;
      n_cmp++; if (mem_stall !== 1'(k < 3)) begin n_bad++; $display("FAIL load mem_stall[%0d] got %b exp %b", k, mem_stall, k < 3); end
      n_cmp++; if (dm.dm_req !== 1'(k > 0)) begin n_bad++; $display("FAIL load dm_req[%0d] got %b exp %b", k, dm.dm_req, k > 0); end
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL load wb_RegWrite_wait[%0d] got %b exp 0", k, wb_RegWrite); end
      if (k > 0) begin
        n_cmp++; if (dm.dm_addr !== 8'h10 || dm.dm_we !== 1'b0) begin n_bad++; $display("FAIL load addr/we[%0d] got %h/%b exp 10/0", k, dm.dm_addr, dm.dm_we); end
      end
      @(negedge clk);
    end
    set_nop();
    n_cmp++; if (wb_mem_data !== 8'hA5) begin n_bad++; $display("FAIL load wb_mem_data got %h exp a5", wb_mem_data); end
    n_cmp++; if (wb_RegWrite !== 1'b1) begin n_bad++; $display("FAIL load wb_RegWrite got %b exp 1", wb_RegWrite); end
    n_cmp++; if (wb_alu_res !== 8'h10 || wb_pc_plus1 !== 8'h11) begin n_bad++; $display("FAIL load alu/pc got %h/%h exp 10/11", wb_alu_res, wb_pc_plus1); end
    n_cmp++; if (wb_RegDistidx !== 2'd1 || wb_MemToReg !== 2'd1) begin n_bad++; $display("FAIL load idx/mtr got %0d/%0d exp 1/1", wb_RegDistidx, wb_MemToReg); end
    n_cmp++; if (dm.dm_req !== 1'b0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL load req/err_after got %b/%b exp 0/0", dm.dm_req, mem_err); end
    @(negedge clk);
    n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL load wb_RegWrite_once got %b exp 0", wb_RegWrite); end
  endtask

  task automatic test_store();
    MemWrite = 1'b1; ALU_res = 8'h20; Rd2 = 8'h5A;
    #1;
    n_cmp++; if (mem_stall !== 1'b1) begin n_bad++; $display("FAIL store mem_stall_issue got %b exp 1", mem_stall); end
    @(negedge clk);
    dm.dm_ack = 1'b1; Rd2 = 8'h00;
    #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL store mem_stall_ack got %b exp 0", mem_stall); end
    n_cmp++; if (dm.dm_req !== 1'b1 || dm.dm_we !== 1'b1) begin n_bad++; $display("FAIL store req/we got %b/%b exp 1/1", dm.dm_req, dm.dm_we); end
    n_cmp++; if (dm.dm_addr !== 8'h20 || dm.dm_wdata !== 8'h5A) begin n_bad++; $display("FAIL store addr/wdata got %h/%h exp 20/5a", dm.dm_addr, dm.dm_wdata); end
    @(negedge clk);
    set_nop();
    n_cmp++; if (dm.dm_req !== 1'b0) begin n_bad++; $display("FAIL store dm_req_after got %b exp 0", dm.dm_req); end
    n_cmp++; if (wb_mem_data !== 8'h00 || wb_alu_res !== 8'h20) begin n_bad++; $display("FAIL store wb_mem/alu got %h/%h exp 00/20", wb_mem_data, wb_alu_res); end
  endtask

  task automatic test_back_to_back();
    logic exp_req[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_stall[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_rw[6]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      set_nop();
      if (c < 2) begin MemRead = 1'b1; ALU_res = 8'h30; RegWrite = 1'b1; end
      else if (c < 4) begin MemWrite = 1'b1; ALU_res = 8'h31; Rd2 = 8'h99; end
      dm.dm_ack = (c == 1 || c == 3); dm.dm_rdata = (c == 1) ? 8'h3C : 8'h00;
      #1;
      n_cmp++; if (dm.dm_req !== exp_req[c]) begin n_bad++; $display("FAIL b2b dm_req[%0d] got %b exp %b", c, dm.dm_req, exp_req[c]); end
      n_cmp++; if (mem_stall !== exp_stall[c]) begin n_bad++; $display("FAIL b2b mem_stall[%0d] got %b exp %b", c, mem_stall, exp_stall[c]); end
      n_cmp++; if (wb_RegWrite !== exp_rw[c]) begin n_bad++; $display("FAIL b2b wb_RegWrite[%0d] got %b exp %b", c, wb_RegWrite, exp_rw[c]); end
      if (c == 1) begin
        n_cmp++; if (dm.dm_addr !== 8'h30 || dm.dm_we !== 1'b0) begin n_bad++; $display("FAIL b2b load addr/we got %h/%b exp 30/0", dm.dm_addr, dm.dm_we); end
      end
      if (c == 2) begin
        n_cmp++; if (wb_mem_data !== 8'h3C) begin n_bad++; $display("FAIL b2b load wb_mem_data got %h exp 3c", wb_mem_data); end
      end
      if (c == 3) begin
        n_cmp++; if (dm.dm_addr !== 8'h31 || dm.dm_we !== 1'b1 || dm.dm_wdata !== 8'h99) begin n_bad++; $display("FAIL b2b store addr/we/wdata got %h/%b/%h exp 31/1/99", dm.dm_addr, dm.dm_we, dm.dm_wdata); end
      end
      if (c == 4) begin
        n_cmp++; if (wb_alu_res !== 8'h31 || wb_mem_data !== 8'h00) begin n_bad++; $display("FAIL b2b store wb_alu/mem got %h/%h exp 31/00", wb_alu_res, wb_mem_data); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    MemRead = 1'b1; ALU_res = 8'h40; RegWrite = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (dm.dm_req !== 1'b1) begin n_bad++; $display("FAIL rstmid dm_req_before got %b exp 1", dm.dm_req); end
    rst = 1'b0;
    #1;
    n_cmp++; if (dm.dm_req !== 1'b0 || mem_stall !== 1'b0) begin n_bad++; $display("FAIL rstmid req/stall got %b/%b exp 0/0", dm.dm_req, mem_stall); end
    n_cmp++; if ({wb_pc_plus1, wb_alu_res, wb_mem_data, wb_ip, wb_RegDistidx, wb_MemToReg, wb_RegWrite} !== 37'd0)
      begin n_bad++; $display("FAIL rstmid wb_fields got alu=%h rw=%b exp 0", wb_alu_res, wb_RegWrite); end
    @(negedge clk);
    set_nop();
    rst = 1'b1;
    dm.dm_ack = 1'b1; dm.dm_rdata = 8'hC3;
    @(negedge clk);
    dm.dm_ack = 1'b0;
    #1;
    n_cmp++; if (dm.dm_req !== 1'b0 || wb_RegWrite !== 1'b0 || wb_mem_data !== 8'h00) begin n_bad++; $display("FAIL rstmid idle_ack req/rw/data got %b/%b/%h exp 0/0/00", dm.dm_req, wb_RegWrite, wb_mem_data); end
    @(negedge clk);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    MemRead = 1'b1; ALU_res = 8'h50; RegWrite = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_cmp++; if (mem_stall !== 1'(k < 15)) begin n_bad++; $display("FAIL tmo mem_stall[%0d] got %b exp %b", k, mem_stall, k < 15); end
      n_cmp++; if (dm.dm_req !== 1'(k > 0)) begin n_bad++; $display("FAIL tmo dm_req[%0d] got %b exp %b", k, dm.dm_req, k > 0); end
      @(negedge clk);
    end
    set_nop();
    n_cmp++; if (dm.dm_req !== 1'b0 || mem_err !== 1'b1) begin n_bad++; $display("FAIL tmo req/err got %b/%b exp 0/1", dm.dm_req, mem_err); end
    n_cmp++; if (wb_mem_data !== 8'hFF || wb_RegWrite !== 1'b0 || wb_alu_res !== 8'h50) begin n_bad++; $display("FAIL tmo wb data/rw/alu got %h/%b/%h exp ff/0/50", wb_mem_data, wb_RegWrite, wb_alu_res); end
    @(negedge clk);
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL tmo mem_err_pulse got %b exp 0", mem_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
